// File: rtl/iir_pkg.sv
// -----------------------------------------------------------------------------
// iir_pkg
// Shared definitions for the IIR tap sequencer:
//   - default datapath geometry (sample/coefficient widths, tap count,
//     multiplier latency, accumulator width)
//   - coefficient bank select encodings
//   - sequencer FSM state enum
// -----------------------------------------------------------------------------
package iir_pkg;

  localparam int DATA_W_DEF    = 24;
  localparam int COEF_W_DEF    = 24;
  localparam int FRAC_BITS_DEF = 22;
  localparam int NUM_TAPS_DEF  = 11;
  localparam int MULT_LAT_DEF  = 2;
  localparam int ACC_W_DEF     = 56;

  localparam logic COEF_SEL_B = 1'b0;
  localparam logic COEF_SEL_A = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_OUTPUT = 2'd3
  } iir_state_t;

endpackage

// File: rtl/iir_mac_mult.sv
// -----------------------------------------------------------------------------
// iir_mac_mult
// Shared signed COEF_W x DATA_W multiplier with a MULT_LAT-deep register
// pipeline. A valid bit and a sign tag travel alongside the product so the
// accumulator knows when a product lands and whether to add or subtract it.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset (clears the pipeline)
//   in_valid   in   issue strobe
//   in_sub     in   tag: 1 = subtract product at the accumulator
//   coef       in   COEF_W signed coefficient
//   data       in   DATA_W signed operand
//   out_valid  out  product valid, MULT_LAT cycles after issue
//   out_sub    out  tag that travelled with the product
//   product    out  COEF_W+DATA_W signed product
// -----------------------------------------------------------------------------
module iir_mac_mult #(
  parameter int DATA_W   = 24,
  parameter int COEF_W   = 24,
  parameter int MULT_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic                       in_sub,
  input  logic [COEF_W-1:0]          coef,
  input  logic [DATA_W-1:0]          data,
  output logic                       out_valid,
  output logic                       out_sub,
  output logic [COEF_W+DATA_W-1:0]   product
);

  localparam int PROD_W = COEF_W + DATA_W;

  // Operands sign-extended to the full product width so a same-width
  // multiply yields the exact signed product in its low PROD_W bits.
  logic [PROD_W-1:0] coef_ext;
  logic [PROD_W-1:0] data_ext;
  logic [PROD_W-1:0] prod_pipe [MULT_LAT];
  logic [MULT_LAT-1:0] valid_pipe;
  logic [MULT_LAT-1:0] sub_pipe;

  assign coef_ext = {{DATA_W{coef[COEF_W-1]}}, coef};
  assign data_ext = {{COEF_W{data[DATA_W-1]}}, data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_pipe[0]  <= '0;
      valid_pipe[0] <= 1'b0;
      sub_pipe[0]   <= 1'b0;
    end else begin
      prod_pipe[0]  <= coef_ext * data_ext;
      valid_pipe[0] <= in_valid;
      sub_pipe[0]   <= in_sub;
    end
  end

  for (genvar gi = 1; gi < MULT_LAT; gi++) begin : g_stage
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        prod_pipe[gi]  <= '0;
        valid_pipe[gi] <= 1'b0;
        sub_pipe[gi]   <= 1'b0;
      end else begin
        prod_pipe[gi]  <= prod_pipe[gi-1];
        valid_pipe[gi] <= valid_pipe[gi-1];
        sub_pipe[gi]   <= sub_pipe[gi-1];
      end
    end
  end

  assign product   = prod_pipe[MULT_LAT-1];
  assign out_valid = valid_pipe[MULT_LAT-1];
  assign out_sub   = sub_pipe[MULT_LAT-1];

endmodule

// File: rtl/iir_tap_sequencer.sv
// -----------------------------------------------------------------------------
// iir_tap_sequencer
// Sequencing controller for a direct-form-I IIR filter. Per accepted sample it
// issues 2*NUM_TAPS products through one shared multiplier in the order
// b[0]*x[0], a[1]*y[1], b[1]*x[1], a[2]*y[2], ..., accumulates b products and
// subtracts a products, then shifts the accumulator down by FRAC_BITS and
// reduces it to DATA_W. Also owns the coefficient register file.
//
// Build option: define IIR_SAT_EN to clamp out-of-range results and report
// them on out_sat; otherwise results wrap and out_sat stays 0.
//
// Ports:
//   clk           in   clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   sample_valid  in   input sample strobe
//   sample_in     in   DATA_W signed sample
//   ready         out  high only while idle
//   out_valid     out  one-cycle result strobe
//   out_data      out  DATA_W signed result, held until the next result
//   out_sat       out  result was clamped (valid with out_valid)
//   coef_we       in   coefficient write strobe (accepted only while idle)
//   coef_sel      in   0 = b bank, 1 = a bank
//   coef_addr     in   tap index; a-bank index k writes a[k+1]
//   coef_wdata    in   COEF_W coefficient value
//   clear_flags   in   clears overrun and coef_err
//   overrun       out  sticky: sample_valid seen while busy
//   coef_err      out  sticky: coefficient write rejected
// -----------------------------------------------------------------------------
module iir_tap_sequencer
  import iir_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int NUM_TAPS  = NUM_TAPS_DEF,
  parameter int MULT_LAT  = MULT_LAT_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic              ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  input  logic              coef_we,
  input  logic              coef_sel,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  input  logic              clear_flags,
  output logic              overrun,
  output logic              coef_err
);

  localparam int TAP_W  = $clog2(NUM_TAPS);
  localparam int CNT_W  = TAP_W + 1;
  localparam int ISSUES = 2 * NUM_TAPS;
  localparam int DRN_W  = $clog2(MULT_LAT + 1);
  localparam int PROD_W = COEF_W + DATA_W;

  iir_state_t state_reg, state_next;

  logic [CNT_W-1:0]  tap_cnt_reg;
  logic [DRN_W-1:0]  drain_cnt_reg;
  logic [ACC_W-1:0]  acc_reg;

  logic [DATA_W-1:0] x_hist [NUM_TAPS];  // x_hist[k] = x[k]
  logic [DATA_W-1:0] y_hist [NUM_TAPS];  // y_hist[k] = y[k+1]
  logic [COEF_W-1:0] b_coef [NUM_TAPS];  // b_coef[k] = b[k]
  logic [COEF_W-1:0] a_coef [NUM_TAPS];  // a_coef[k] = a[k+1]

  logic              accept;
  logic              coef_addr_ok;
  logic              coef_wr;
  logic              coef_reject;

  logic [TAP_W-1:0]  tap_idx;
  logic              issue_valid;
  logic              issue_sub;
  logic [COEF_W-1:0] issue_coef;
  logic [DATA_W-1:0] issue_data;

  logic              mult_valid;
  logic              mult_sub;
  logic [PROD_W-1:0] mult_product;
  logic [ACC_W-1:0]  prod_ext;

  logic signed [ACC_W-1:0] acc_shift;
  logic [DATA_W-1:0] result;
  logic              res_sat;

  assign ready        = (state_reg == ST_IDLE);
  assign accept       = ready & sample_valid;
  assign coef_addr_ok = (int'(coef_addr) < NUM_TAPS);
  assign coef_wr      = coef_we & ready & coef_addr_ok;
  assign coef_reject  = coef_we & ~(ready & coef_addr_ok);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (sample_valid) state_next = ST_RUN;
      ST_RUN:    if (tap_cnt_reg == CNT_W'(ISSUES - 1)) state_next = ST_DRAIN;
      ST_DRAIN:  if (drain_cnt_reg == DRN_W'(MULT_LAT - 1)) state_next = ST_OUTPUT;
      ST_OUTPUT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Coefficient register file and sample/result histories
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        b_coef[gi] <= '0;
        a_coef[gi] <= '0;
      end else if (coef_wr && (coef_addr == 4'(gi))) begin
        if (coef_sel == COEF_SEL_A) a_coef[gi] <= coef_wdata;
        else                        b_coef[gi] <= coef_wdata;
      end
    end

    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          x_hist[gi] <= '0;
          y_hist[gi] <= '0;
        end else begin
          if (accept)                  x_hist[gi] <= sample_in;
          if (state_reg == ST_OUTPUT)  y_hist[gi] <= result;
        end
      end
    end else begin : g_shift
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          x_hist[gi] <= '0;
          y_hist[gi] <= '0;
        end else begin
          if (accept)                  x_hist[gi] <= x_hist[gi-1];
          if (state_reg == ST_OUTPUT)  y_hist[gi] <= y_hist[gi-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue: even counts pair b[k] with x[k], odd counts pair a[k+1] with y[k+1]
  // ---------------------------------------------------------------------------
  assign tap_idx     = tap_cnt_reg[CNT_W-1:1];
  assign issue_valid = (state_reg == ST_RUN);
  assign issue_sub   = tap_cnt_reg[0];
  assign issue_coef  = issue_sub ? a_coef[tap_idx] : b_coef[tap_idx];
  assign issue_data  = issue_sub ? y_hist[tap_idx] : x_hist[tap_idx];

  iir_mac_mult #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .MULT_LAT (MULT_LAT)
  ) u_mult (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (issue_valid),
    .in_sub    (issue_sub),
    .coef      (issue_coef),
    .data      (issue_data),
    .out_valid (mult_valid),
    .out_sub   (mult_sub),
    .product   (mult_product)
  );

  assign prod_ext = {{(ACC_W - PROD_W){mult_product[PROD_W-1]}}, mult_product};

  // ---------------------------------------------------------------------------
  // Result scaling: arithmetic shift truncates toward minus infinity
  // ---------------------------------------------------------------------------
  assign acc_shift = $signed(acc_reg) >>> FRAC_BITS;

`ifdef IIR_SAT_EN
  logic [ACC_W-DATA_W:0] upper_bits;
  logic                  fits;
  // The value fits when every bit from the DATA_W sign bit upward agrees.
  assign upper_bits = acc_shift[ACC_W-1:DATA_W-1];
  assign fits       = (&upper_bits) | ~(|upper_bits);
  assign res_sat    = ~fits;
  assign result     = fits ? acc_shift[DATA_W-1:0] :
                      (acc_shift[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                          : {1'b0, {(DATA_W-1){1'b1}}});
`else
  logic unused_hi;
  assign unused_hi = ^acc_shift[ACC_W-1:DATA_W];
  assign res_sat   = 1'b0;
  assign result    = acc_shift[DATA_W-1:0];
`endif

  // ---------------------------------------------------------------------------
  // Sequencer state, accumulator, outputs and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      tap_cnt_reg   <= '0;
      drain_cnt_reg <= '0;
      acc_reg       <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_sat       <= 1'b0;
      overrun       <= 1'b0;
      coef_err      <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_valid <= (state_reg == ST_OUTPUT);

      if (state_reg == ST_OUTPUT) begin
        out_data <= result;
        out_sat  <= res_sat;
      end

      if (accept)                   tap_cnt_reg <= '0;
      else if (state_reg == ST_RUN) tap_cnt_reg <= tap_cnt_reg + CNT_W'(1);

      if (state_reg == ST_RUN)        drain_cnt_reg <= '0;
      else if (state_reg == ST_DRAIN) drain_cnt_reg <= drain_cnt_reg + DRN_W'(1);

      // The pipeline is always empty by the time a new sample is accepted.
      if (accept)          acc_reg <= '0;
      else if (mult_valid) acc_reg <= mult_sub ? (acc_reg - prod_ext)
                                               : (acc_reg + prod_ext);

      // Setting events take priority over clear_flags.
      overrun  <= (sample_valid & ~ready) | (overrun & ~clear_flags);
      coef_err <= coef_reject | (coef_err & ~clear_flags);
    end
  end

endmodule
